mult_div: RTL and testbench

MULT_DIV -- requirements
Module: mult_div

---
 rtl/mult_div_pkg.sv | 25 ++
 rtl/mult_div_addsub_w.sv | 28 ++
 rtl/mult_div.sv | 221 ++++++++++++++++++++++
 tb/tb_mult_div.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared definitions for the iterative multiply/divide unit.
//   - default operand width and iteration count
//   - FSM state encoding
//   - divide exception causes, decided when the operands are latched
package mult_div_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int ITER_DEF  = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Exception causes that are known at the start of a divide. A multiply
  // overflow depends on the full product and is detected at the end instead.
  typedef enum logic [1:0] {
    EXC_NONE     = 2'd0,
    EXC_DIV_ZERO = 2'd1,
    EXC_DIV_OVF  = 2'd2
  } exc_e;

endpackage

// File: rtl/mult_div_addsub_w.sv
// addsub_w: combinational (W+1)-bit adder/subtractor shared by the Booth
// multiply step and the restoring divide step.
//   a_i, b_i : W+1 bit operands
//   sub_i    : 1 -> a_i - b_i, 0 -> a_i + b_i
//   sum_o    : W+1 bit result
//   cout_o   : carry out; for subtraction 1 means no borrow (a_i >= b_i unsigned)
module addsub_w #(
  parameter int W = 32
) (
  input  logic [W:0] a_i,
  input  logic [W:0] b_i,
  input  logic       sub_i,
  output logic [W:0] sum_o,
  output logic       cout_o
);

  logic [W:0]   b_eff;
  logic [W+1:0] full;

  always_comb begin
    b_eff = sub_i ? ~b_i : b_i;
    full  = {1'b0, a_i} + {1'b0, b_eff} + {{(W+1){1'b0}}, sub_i};
  end

  assign sum_o  = full[W:0];
  assign cout_o = full[W+1];

endmodule

// File: rtl/mult_div.sv
// mult_div: iterative signed multiply / divide unit, one bit per cycle.
//   clk            : clock, rising edge
//   clr_n          : asynchronous active-low reset
//   data_operandA  : multiplicand / dividend (signed)
//   data_operandB  : multiplier / divisor (signed)
//   ctrl_MULT      : start multiply (priority over ctrl_DIV)
//   ctrl_DIV       : start divide
//   data_result    : result, held from DONE until the next start
//   data_exception : multiply overflow, divide by zero, or MIN / -1
//   data_resultRDY : one-cycle strobe in DONE
//   busy           : high while in MUL or DIV
//
// Handshake: a request is taken on any rising edge where the unit is in IDLE
// or DONE and ctrl_MULT or ctrl_DIV is high; there is no back-pressure on the
// result, which is valid only in the cycle data_resultRDY is high.
//
// Multiply is radix-2 Booth over {hi_q, lo_q, qm1_q}. Divide is restoring on
// magnitudes with hi_q as partial remainder and lo_q as dividend/quotient.
module mult_div
  import mult_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ITER  = ITER_DEF
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, m_q;
  logic             qm1_q;
  logic             neg_q;
  exc_e             cause_q;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;

  logic             accept;
  logic             last;
  logic             running;

  logic [WIDTH:0]   add_a, add_b, add_sum;
  logic             add_sub, add_cout;
  logic [WIDTH-1:0] hi_step, lo_step;
  logic             qm1_step;
  logic [WIDTH-1:0] fin_res;
  logic             fin_exc;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] q_signed;

  assign accept  = ((state_q == S_IDLE) || (state_q == S_DONE)) && (ctrl_MULT || ctrl_DIV);
  assign running = (state_q == S_MUL) || (state_q == S_DIV);
  assign last    = (cnt_q == CNT_LAST);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (ctrl_MULT)     state_d = S_MUL;
        else if (ctrl_DIV) state_d = S_DIV;
        else               state_d = S_IDLE;
      end
      S_MUL, S_DIV: begin
        if (last) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy           = 1'b0;
    data_resultRDY = 1'b0;
    case (state_q)
      S_MUL, S_DIV: busy           = 1'b1;
      S_DONE:       data_resultRDY = 1'b1;
      default: ;
    endcase
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;

  // ---------------- shared adder ----------------
  addsub_w #(.W(WIDTH)) u_addsub (
    .a_i    (add_a),
    .b_i    (add_b),
    .sub_i  (add_sub),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // Operand magnitudes; |MIN| is representable as an unsigned WIDTH value.
  always_comb begin
    mag_a = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    mag_b = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
  end

  // ---------------- one iteration step ----------------
  always_comb begin
    add_a    = {hi_q[WIDTH-1], hi_q};
    add_b    = {m_q[WIDTH-1], m_q};
    add_sub  = 1'b0;
    hi_step  = hi_q;
    lo_step  = lo_q;
    qm1_step = qm1_q;
    if (state_q == S_DIV) begin
      // Shift the next dividend bit into the remainder and trial-subtract.
      add_a   = {hi_q, lo_q[WIDTH-1]};
      add_b   = {1'b0, m_q};
      add_sub = 1'b1;
      hi_step = add_cout ? add_sum[WIDTH-1:0] : add_a[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], add_cout};
    end else begin
      // Booth pair {lo_q[0], qm1_q}: 01 add, 10 subtract, else shift only.
      // The extra adder bit keeps the sum exact before the arithmetic shift.
      add_sub  = (lo_q[0] == 1'b1) && (qm1_q == 1'b0);
      qm1_step = lo_q[0];
      if (lo_q[0] != qm1_q) begin
        hi_step = add_sum[WIDTH:1];
        lo_step = {add_sum[0], lo_q[WIDTH-1:1]};
      end else begin
        hi_step = {hi_q[WIDTH-1], hi_q[WIDTH-1:1]};
        lo_step = {hi_q[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  // ---------------- final result from the last step ----------------
  always_comb begin
    q_signed = neg_q ? (~lo_step + 1'b1) : lo_step;
    fin_res  = lo_step;
    fin_exc  = 1'b0;
    if (state_q == S_MUL) begin
      fin_res = lo_step;
      fin_exc = (hi_step != (lo_step[WIDTH-1] ? ALL_ONES : '0));
    end else begin
      case (cause_q)
        EXC_DIV_ZERO: begin
          fin_res = '0;
          fin_exc = 1'b1;
        end
        EXC_DIV_OVF: begin
          // |MIN| / 1 with positive sign already yields MIN.
          fin_res = q_signed;
          fin_exc = 1'b1;
        end
        default: begin
          fin_res = q_signed;
          fin_exc = 1'b0;
        end
      endcase
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      qm1_q    <= 1'b0;
      neg_q    <= 1'b0;
      cause_q  <= EXC_NONE;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else if (accept) begin
      cnt_q <= '0;
      hi_q  <= '0;
      qm1_q <= 1'b0;
      if (ctrl_MULT) begin
        lo_q    <= data_operandB;
        m_q     <= data_operandA;
        neg_q   <= 1'b0;
        cause_q <= EXC_NONE;
      end else begin
        lo_q  <= mag_a;
        m_q   <= mag_b;
        neg_q <= (data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1]);
        if (data_operandB == '0)
          cause_q <= EXC_DIV_ZERO;
        else if ((data_operandA == MIN_VAL) && (data_operandB == ALL_ONES))
          cause_q <= EXC_DIV_OVF;
        else
          cause_q <= EXC_NONE;
      end
    end else if (running) begin
      hi_q  <= hi_step;
      lo_q  <= lo_step;
      qm1_q <= qm1_step;
      cnt_q <= last ? '0 : cnt_q + 1'b1;
      if (last) begin
        result_q <= fin_res;
        exc_q    <= fin_exc;
      end
    end
  end

endmodule

// File: tb/tb_mult_div.sv
module tb_mult_div;

  logic        clk;
  logic        clr_n;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks;
  int errors;

  mult_div #(.WIDTH(32), .ITER(32)) dut (
    .clk            (clk),
    .clr_n          (clr_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; the request is sampled on the next edge.
  task automatic start_op(input logic m, input logic d, input logic [31:0] oa, input logic [31:0] ob);
    data_operandA = oa;
    data_operandB = ob;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    @(posedge clk);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  // Counts edges after the start edge until RDY is seen (0 = never seen).
  task automatic wait_rdy(output int n, output int gaps);
    n    = 0;
    gaps = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (data_resultRDY) begin
        n = i;
        break;
      end
      if (!busy) gaps++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    clr_n = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #1;
    checks++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: got res=%h exc=%b rdy=%b busy=%b, want all 0",
               data_result, data_exception, data_resultRDY, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    clr_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got rdy=%b busy=%b, want 0 0", data_resultRDY, busy);
    end
  endtask

  task automatic test_mult;
    logic [31:0] va[4]   = '{32'd7, 32'h0001_0000, 32'hFFFF_FFFB, 32'h8000_0000};
    logic [31:0] vb[4]   = '{32'hFFFF_FFFD, 32'h0001_0000, 32'hFFFF_FFFA, 32'hFFFF_FFFF};
    logic [31:0] vres[4] = '{32'hFFFF_FFEB, 32'h0000_0000, 32'd30, 32'h8000_0000};
    logic        vexc[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int n, gaps;
    for (int i = 0; i < 4; i++) begin
      start_op(1'b1, 1'b0, va[i], vb[i]);
      wait_rdy(n, gaps);
      checks++;
      if (n !== 32) begin
        errors++;
        $display("FAIL mult_latency[%0d]: got %0d edges, want 32", i, n);
      end
      checks++;
      if (gaps !== 0) begin
        errors++;
        $display("FAIL mult_busy[%0d]: busy low in %0d cycles, want 0", i, gaps);
      end
      checks++;
      if (data_result !== vres[i] || data_exception !== vexc[i]) begin
        errors++;
        $display("FAIL mult_result[%0d]: got %h exc=%b, want %h exc=%b",
                 i, data_result, data_exception, vres[i], vexc[i]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (data_resultRDY !== 1'b0 || data_result !== vres[i] || data_exception !== vexc[i]) begin
        errors++;
        $display("FAIL mult_hold[%0d]: got rdy=%b res=%h exc=%b, want 0 %h %b",
                 i, data_resultRDY, data_result, data_exception, vres[i], vexc[i]);
      end
    end
  endtask

  task automatic test_div;
    logic [31:0] va[5]   = '{32'hFFFF_FFEF, 32'd100, 32'h8000_0000, 32'd17, 32'd7};
    logic [31:0] vb[5]   = '{32'd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'd9};
    logic [31:0] vres[5] = '{32'hFFFF_FFFD, 32'd0, 32'h8000_0000, 32'hFFFF_FFFD, 32'd0};
    logic        vexc[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int n, gaps;
    for (int i = 0; i < 5; i++) begin
      start_op(1'b0, 1'b1, va[i], vb[i]);
      wait_rdy(n, gaps);
      checks++;
      if (n !== 32) begin
        errors++;
        $display("FAIL div_latency[%0d]: got %0d edges, want 32", i, n);
      end
      checks++;
      if (data_result !== vres[i] || data_exception !== vexc[i]) begin
        errors++;
        $display("FAIL div_result[%0d]: got %h exc=%b, want %h exc=%b",
                 i, data_result, data_exception, vres[i], vexc[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_priority;
    int n, gaps;
    start_op(1'b1, 1'b1, 32'd6, 32'd3);
    wait_rdy(n, gaps);
    checks++;
    if (n !== 32 || data_result !== 32'd18 || data_exception !== 1'b0) begin
      errors++;
      $display("FAIL priority: got n=%0d res=%h exc=%b, want 32 00000012 0",
               n, data_result, data_exception);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignore;
    int rdy_cnt, first;
    logic [31:0] res_at_rdy;
    rdy_cnt = 0;
    first = 0;
    res_at_rdy = '0;
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk);
      #1;
      if (data_resultRDY) begin
        rdy_cnt++;
        first = e;
        res_at_rdy = data_result;
      end
      if (e == 4) begin
        ctrl_DIV = 1'b1;
        ctrl_MULT = 1'b1;
        data_operandA = 32'd1;
        data_operandB = 32'd1;
      end else if (e == 5) begin
        ctrl_DIV = 1'b0;
        ctrl_MULT = 1'b0;
      end
    end
    checks++;
    if (rdy_cnt !== 1 || first !== 32) begin
      errors++;
      $display("FAIL ignore_count: got %0d strobes first at %0d, want 1 at 32", rdy_cnt, first);
    end
    checks++;
    if (res_at_rdy !== 32'd14) begin
      errors++;
      $display("FAIL ignore_result: got %h, want 0000000e", res_at_rdy);
    end
  endtask

  task automatic test_reset_midop;
    int rdy_cnt, n, gaps;
    rdy_cnt = 0;
    start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    repeat (9) @(posedge clk);
    #3;
    clr_n = 1'b0;
    #1;
    checks++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
      errors++;
      $display("FAIL midop_reset: got res=%h exc=%b rdy=%b busy=%b, want all 0",
               data_result, data_exception, data_resultRDY, busy);
    end
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      #1;
      if (data_resultRDY) rdy_cnt++;
    end
    checks++;
    if (rdy_cnt !== 0) begin
      errors++;
      $display("FAIL midop_no_rdy: got %0d strobes, want 0", rdy_cnt);
    end
    start_op(1'b0, 1'b1, 32'hFFFF_FFEC, 32'hFFFF_FFFC);
    wait_rdy(n, gaps);
    checks++;
    if (n !== 32 || data_result !== 32'd5 || data_exception !== 1'b0) begin
      errors++;
      $display("FAIL midop_recover: got n=%0d res=%h exc=%b, want 32 00000005 0",
               n, data_result, data_exception);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int n, gaps;
    start_op(1'b1, 1'b0, 32'd6, 32'd7);
    wait_rdy(n, gaps);
    checks++;
    if (n !== 32 || data_result !== 32'd42) begin
      errors++;
      $display("FAIL b2b_first: got n=%0d res=%h, want 32 0000002a", n, data_result);
    end
    // Still in DONE: this request is taken on the very next edge.
    start_op(1'b0, 1'b1, 32'd9, 32'd3);
    checks++;
    if (busy !== 1'b1 || data_resultRDY !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b rdy=%b, want 1 0", busy, data_resultRDY);
    end
    wait_rdy(n, gaps);
    checks++;
    if (n !== 32 || data_result !== 32'd3 || data_exception !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got n=%0d res=%h exc=%b, want 32 00000003 0",
               n, data_result, data_exception);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_mult;
    test_div;
    test_priority;
    test_ignore;
    test_reset_midop;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
